// File: rtl/y_pkg.sv
// Shared constants, the queue-entry type and a saturating adder for the y_prefetch fetch unit.
package y_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } q_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/y_prefetch_if.sv
// Fetch bus: instruction-memory request/response plus the decode-facing queue head.
// Handshakes: a request issues on a rising edge with imem_req&imem_gnt high; responses
// (imem_rvalid) return in issue order with no back-pressure; decode pops on ins_valid&ins_ready.
interface y_prefetch_if;
    import y_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] ins_pc;
    logic [XLEN-1:0] PCp4;
    logic            ins_valid;
    logic            ins_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output ins, ins_pc, PCp4, ins_valid,
        input  ins_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  ins, ins_pc, PCp4, ins_valid,
        output ins_ready
    );

endinterface

// File: rtl/y_pf_fifo.sv
// Synchronous FIFO with flush and occupancy count; head word is read combinationally.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module y_pf_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/y_prefetch.sv
// Instruction prefetcher: issues sequential fetches, queues in-order responses for decode,
// and discards stale responses after a redirect. Define PF_STATS_EN to add fetch/flush counters.
module y_prefetch
    import y_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            INT,
    input  logic [XLEN-1:0] entryPoint,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef PF_STATS_EN
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed,
`endif
    y_prefetch_if.master    bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = 16;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [DW-1:0]   discard;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   out_cnt;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] tag_pc;
    q_entry_t        q_head;
    q_entry_t        q_in;
    logic            q_valid;
    logic            issue;
    logic            issued;
    logic            resp_drop;
    logic            resp_take;
    logic            resp_any;
    logic            pop;

    assign inflight = {1'b0, q_count} + {1'b0, out_cnt};
    assign issue    = !INT && !redirect && (inflight < DEPTH_W) && (out_cnt < CW'(MAX_OUT));
    assign issued   = issue && bus.imem_gnt;

    // A response with nothing in flight is a protocol error and is ignored entirely.
    assign resp_drop = bus.imem_rvalid && (discard != '0);
    assign resp_take = bus.imem_rvalid && (discard == '0) && (out_cnt != '0);
    assign resp_any  = resp_drop || resp_take;

    assign q_valid = (q_count != '0);
    assign pop     = q_valid && bus.ins_ready;
    assign q_in    = '{pc: tag_pc, ins: bus.imem_rdata};

    y_pf_fifo #(.W($bits(q_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (INT),
        .flush (redirect),
        .push  (resp_take && !redirect),
        .pop   (pop && !redirect),
        .wdata (q_in),
        .rdata (q_head),
        .count (q_count)
    );

    // Tag FIFO pairs each in-order response with the address that requested it.
    y_pf_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tags (
        .clk   (clk),
        .rst   (INT),
        .flush (redirect),
        .push  (issued),
        .pop   (resp_take && !redirect),
        .wdata (fetch_pc),
        .rdata (tag_pc),
        .count (out_cnt)
    );

    // On redirect every request still in flight becomes a discard, minus any answered this cycle.
    always_ff @(posedge clk or posedge INT) begin
        if (INT) begin
            fetch_pc <= entryPoint;
            discard  <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h3;
            discard  <= discard + DW'(out_cnt) - DW'(resp_any);
        end else begin
            if (issued)    fetch_pc <= fetch_pc + 32'd4;
            if (resp_drop) discard  <= discard - DW'(1);
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.ins_valid = q_valid;
    assign bus.ins       = q_valid ? q_head.ins : NOP_INS;
    assign bus.ins_pc    = INT ? entryPoint : (q_valid ? q_head.pc : fetch_pc);
    assign bus.PCp4      = bus.ins_pc + 32'd4;

`ifdef PF_STATS_EN
    logic [31:0] flush_inc;

    // Flushed work: entries still queued at redirect (a same-cycle pop is consumed) plus dropped responses.
    always_comb begin
        flush_inc = '0;
        if (redirect) flush_inc = 32'(q_count) - 32'(pop);
        if (resp_drop || (redirect && resp_take)) flush_inc = flush_inc + 32'd1;
    end

    always_ff @(posedge clk or posedge INT) begin
        if (INT) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            stat_fetched <= sat_add(stat_fetched, 32'(resp_take && !redirect));
            stat_flushed <= sat_add(stat_flushed, flush_inc);
        end
    end
`endif

endmodule

// File: tb/tb_y_prefetch.sv
// Self-checking bench for y_prefetch: memory responder, randomized traffic and a
// program-order model of the instruction stream decode should observe.
`timescale 1ns/1ps
module tb_y_prefetch;
    import y_pkg::*;

    typedef struct {
        bit          redir;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pcp4;
    } ev_t;

    logic        clk = 1'b0;
    logic        INT;
    logic [31:0] entryPoint;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef PF_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    y_prefetch_if bus();

    y_prefetch #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk         (clk),
        .INT         (INT),
        .entryPoint  (entryPoint),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef PF_STATS_EN
        .stat_fetched(stat_fetched),
        .stat_flushed(stat_flushed),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          gnt_mode;
    int          ready_mode;
    bit          rsp_en;
    int          rsp_pct;
    int          cyc = 0;
    logic [31:0] mem_q[$];
    int          mem_t[$];
    logic [31:0] issued_q[$];
    ev_t         ev_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_pc_q[$];
    logic [31:0] got_ins_q[$];
    logic [31:0] got_p4_q[$];
    bit          last_req;
    bit          last_valid;
    logic [31:0] last_pc;
    logic [31:0] last_ins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Program-order model: after each redirect decode sees target, target+4, ... (wrapping).
    function automatic void build_model();
        logic [31:0] pc;
        bit synced;
        exp_q.delete(); got_pc_q.delete(); got_ins_q.delete(); got_p4_q.delete();
        synced = 1'b0;
        pc = '0;
        foreach (ev_q[i]) begin
            if (ev_q[i].redir) begin
                synced = 1'b1;
                pc = ev_q[i].pc & ~32'h3;
            end else if (synced) begin
                exp_q.push_back(pc);
                got_pc_q.push_back(ev_q[i].pc);
                got_ins_q.push_back(ev_q[i].ins);
                got_p4_q.push_back(ev_q[i].pcp4);
                pc = pc + 32'd4;
            end
        end
    endfunction

    // One cycle: drive inputs at negedge, sample just after, let the posedge happen.
    task automatic step(input bit do_redir, input logic [31:0] tgt);
        logic [31:0] a;
        ev_t e;
        @(negedge clk);
        redirect      = do_redir;
        redirect_pc   = tgt;
        bus.ins_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        bus.imem_gnt  = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
        if (rsp_en && mem_q.size() > 0 && mem_t[0] < cyc && $urandom_range(0, 99) < rsp_pct) begin
            a = mem_q.pop_front();
            void'(mem_t.pop_front());
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(a);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        last_req   = bus.imem_req;
        last_valid = bus.ins_valid;
        last_pc    = bus.ins_pc;
        last_ins   = bus.ins;
        if (bus.imem_req && bus.imem_gnt) begin
            mem_q.push_back(bus.imem_addr);
            mem_t.push_back(cyc);
            issued_q.push_back(bus.imem_addr);
        end
        if (bus.ins_valid && bus.ins_ready) begin
            e.redir = 1'b0; e.pc = bus.ins_pc; e.ins = bus.ins; e.pcp4 = bus.PCp4;
            ev_q.push_back(e);
        end
        if (do_redir) begin
            e.redir = 1'b1; e.pc = tgt; e.ins = '0; e.pcp4 = '0;
            ev_q.push_back(e);
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic test_reset();
        INT = 1'b1; entryPoint = 32'h80; redirect = 1'b0; redirect_pc = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.ins_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        total++; if (bus.ins_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.ins_valid); end
        total++; if (bus.ins !== NOP_INS) begin bad++; $display("FAIL reset_ins: got %h want %h", bus.ins, NOP_INS); end
        total++; if (bus.ins_pc !== 32'h80) begin bad++; $display("FAIL reset_pc: got %h want 00000080", bus.ins_pc); end
        total++; if (bus.PCp4 !== 32'h84) begin bad++; $display("FAIL reset_pcp4: got %h want 00000084", bus.PCp4); end
    endtask

    task automatic test_stream();
        gnt_mode = 1; ready_mode = 0; rsp_en = 1'b1; rsp_pct = 100;
        issued_q.delete(); ev_q.delete();
        @(negedge clk); INT = 1'b0;
        @(posedge clk);
        step(1'b0, '0);
        total++; if (last_req !== 1'b1) begin bad++; $display("FAIL stream_first_req: got %b want 1", last_req); end
        total++; if (issued_q.size() != 1 || issued_q[0] !== 32'h80) begin
            bad++; $display("FAIL stream_first_addr: got %h want 00000080", issued_q.size() ? issued_q[0] : 32'hx); end
        step(1'b0, '0);
        total++; if (last_valid !== 1'b0) begin bad++; $display("FAIL stream_latency_early: got %b want 0", last_valid); end
        step(1'b0, '0);
        total++; if (last_valid !== 1'b1 || last_pc !== 32'h80) begin
            bad++; $display("FAIL stream_first_valid: got valid=%b pc=%h want 1/00000080", last_valid, last_pc); end
        total++; if (last_ins !== mem_word(32'h80)) begin bad++; $display("FAIL stream_first_ins: got %h want %h", last_ins, mem_word(32'h80)); end
    endtask

    task automatic test_stall();
        int unstable = 0;
        repeat (10) begin
            step(1'b0, '0);
            if (last_valid !== 1'b1 || last_pc !== 32'h80) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); end
        total++; if (last_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", last_req); end
        total++; if (issued_q.size() != 4 || mem_q.size() != 0) begin
            bad++; $display("FAIL stall_occupancy: got issued=%0d pending=%0d want 4/0", issued_q.size(), mem_q.size()); end
        for (int i = 0; i < issued_q.size(); i++) begin
            total++; if (issued_q[i] !== 32'h80 + 32'(4 * i)) begin
                bad++; $display("FAIL stall_addr[%0d]: got %h want %h", i, issued_q[i], 32'h80 + 32'(4 * i)); end
        end
    endtask

    task automatic test_full_pop_push();
        ready_mode = 1; ev_q.delete();
        step(1'b0, '0);
        total++; if (last_req !== 1'b0) begin bad++; $display("FAIL full_no_issue: got %b want 0", last_req); end
        repeat (7) step(1'b0, '0);
        total++; if (ev_q.size() != 8) begin bad++; $display("FAIL full_pops: got %0d want 8", ev_q.size()); end
        for (int i = 0; i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i].pc !== 32'h80 + 32'(4 * i) || ev_q[i].ins !== mem_word(ev_q[i].pc) || ev_q[i].pcp4 !== ev_q[i].pc + 32'd4) begin
                bad++; $display("FAIL full_order[%0d]: got pc=%h ins=%h want pc=%h ins=%h", i, ev_q[i].pc, ev_q[i].ins,
                                32'h80 + 32'(4 * i), mem_word(32'h80 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_redirect();
        ready_mode = 1; rsp_en = 1'b0;
        repeat (6) step(1'b0, '0);
        total++; if (mem_q.size() != 2 || last_valid !== 1'b0) begin
            bad++; $display("FAIL redir_setup: got pending=%0d valid=%b want 2/0", mem_q.size(), last_valid); end
        ev_q.delete(); issued_q.delete();
        step(1'b1, 32'h203);
        total++; if (last_req !== 1'b0) begin bad++; $display("FAIL redir_no_issue: got %b want 0", last_req); end
        rsp_en = 1'b1;
        repeat (10) step(1'b0, '0);
        total++; if (issued_q.size() == 0 || issued_q[0] !== 32'h200) begin
            bad++; $display("FAIL redir_addr: got %h want 00000200", issued_q.size() ? issued_q[0] : 32'hx); end
        build_model();
        total++; if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h200) begin
            bad++; $display("FAIL redir_first_pc: got %h want 00000200", got_pc_q.size() ? got_pc_q[0] : 32'hx); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            total++; if (got_pc_q[i] !== exp_q[i] || got_ins_q[i] !== mem_word(exp_q[i])) begin
                bad++; $display("FAIL redir_seq[%0d]: got pc=%h ins=%h want pc=%h", i, got_pc_q[i], got_ins_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_int_midstream();
        logic [31:0] a;
        ready_mode = 1; rsp_en = 1'b1;
        repeat (4) step(1'b0, '0);
        ready_mode = 0; rsp_en = 1'b0;
        repeat (3) step(1'b0, '0);
        total++; if (mem_q.size() != 2 || last_valid !== 1'b1) begin
            bad++; $display("FAIL int_setup: got pending=%0d valid=%b want 2/1", mem_q.size(), last_valid); end
        @(negedge clk);
        INT = 1'b1; entryPoint = 32'h1000; redirect = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.ins_ready = 1'b0;
        #1;
        total++; if (bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            bad++; $display("FAIL int_immediate: got valid=%b req=%b want 0/0", bus.ins_valid, bus.imem_req); end
        total++; if (bus.ins_pc !== 32'h1000) begin bad++; $display("FAIL int_pc: got %h want 00001000", bus.ins_pc); end
        repeat (2) @(posedge clk);
        @(negedge clk); INT = 1'b0;
        @(posedge clk);
        while (mem_q.size() > 0) begin
            @(negedge clk);
            a = mem_q.pop_front();
            void'(mem_t.pop_front());
            bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(a);
            @(posedge clk);
        end
        @(negedge clk); bus.imem_rvalid = 1'b0; #1;
        total++; if (bus.ins_valid !== 1'b0 || bus.ins !== NOP_INS) begin
            bad++; $display("FAIL int_late_rvalid: got valid=%b ins=%h want 0/%h", bus.ins_valid, bus.ins, NOP_INS); end
        total++; if (bus.imem_addr !== 32'h1000) begin bad++; $display("FAIL int_fetch_pc: got %h want 00001000", bus.imem_addr); end
        ev_q.delete(); issued_q.delete();
        gnt_mode = 1; ready_mode = 1; rsp_en = 1'b1;
        repeat (8) step(1'b0, '0);
        total++; if (issued_q.size() == 0 || issued_q[0] !== 32'h1000) begin
            bad++; $display("FAIL int_refetch_addr: got %h want 00001000", issued_q.size() ? issued_q[0] : 32'hx); end
        total++; if (ev_q.size() < 3) begin bad++; $display("FAIL int_refetch_count: got %0d want >=3", ev_q.size()); end
        for (int i = 0; i < ev_q.size(); i++) begin
            total++; if (ev_q[i].pc !== 32'h1000 + 32'(4 * i) || ev_q[i].ins !== mem_word(32'h1000 + 32'(4 * i))) begin
                bad++; $display("FAIL int_refetch[%0d]: got pc=%h ins=%h want pc=%h", i, ev_q[i].pc, ev_q[i].ins, 32'h1000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_wrap();
        ev_q.delete(); issued_q.delete();
        step(1'b1, 32'hFFFF_FFF8);
        repeat (12) step(1'b0, '0);
        total++; if (issued_q.size() < 4 || issued_q[1] !== 32'hFFFF_FFFC || issued_q[2] !== 32'h0 || issued_q[3] !== 32'h4) begin
            bad++; $display("FAIL wrap_addr: got %0d issued, [2]=%h want [2]=00000000", issued_q.size(),
                            issued_q.size() > 2 ? issued_q[2] : 32'hx); end
        build_model();
        total++; if (got_pc_q.size() < 4 || got_pc_q[2] !== 32'h0 || got_p4_q[1] !== 32'h0) begin
            bad++; $display("FAIL wrap_pop: got %0d pops, pc[2]=%h want 00000000", got_pc_q.size(),
                            got_pc_q.size() > 2 ? got_pc_q[2] : 32'hx); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            total++; if (got_pc_q[i] !== exp_q[i] || got_ins_q[i] !== mem_word(exp_q[i])) begin
                bad++; $display("FAIL wrap_seq[%0d]: got pc=%h ins=%h want pc=%h", i, got_pc_q[i], got_ins_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit r;
        gnt_mode = 2; ready_mode = 2; rsp_en = 1'b1; rsp_pct = 70;
        ev_q.delete(); issued_q.delete();
        step(1'b1, 32'h0000_4002);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 6);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            step(r, tgt);
        end
        gnt_mode = 0; ready_mode = 1; rsp_pct = 100;
        repeat (30) step(1'b0, '0);
        total++; if (mem_q.size() != 0 || last_valid !== 1'b0) begin
            bad++; $display("FAIL rand_drain: got pending=%0d valid=%b want 0/0", mem_q.size(), last_valid); end
        build_model();
        total++; if (got_pc_q.size() < 20) begin bad++; $display("FAIL rand_progress: got %0d pops want >=20", got_pc_q.size()); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            total++;
            if (got_pc_q[i] !== exp_q[i] || got_ins_q[i] !== mem_word(exp_q[i]) || got_p4_q[i] !== exp_q[i] + 32'd4) begin
                bad++; $display("FAIL rand_seq[%0d]: got pc=%h ins=%h p4=%h want pc=%h ins=%h", i, got_pc_q[i], got_ins_q[i],
                                got_p4_q[i], exp_q[i], mem_word(exp_q[i]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_full_pop_push();
        test_redirect();
        test_int_midstream();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y_prefetch.md
Y_PREFETCH -- requirements
Module: y_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of instruction queue entries (power of two, 2..8).
REQ-002 Parameter MAX_OUT, default 2, SHALL set the maximum number of outstanding instruction-memory requests (1..DEPTH).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 INT  in  1  SHALL be the asynchronous active-high reset; it also loads entryPoint into the fetch PC.
REQ-005 entryPoint  in  32  SHALL be the fetch start address applied while INT is high.
REQ-006 imem_req  out  1  SHALL be the fetch request-valid signal.
REQ-007 imem_addr  out  32  SHALL be the fetch word address.
REQ-008 imem_gnt  in  1  SHALL accept the request (req&gnt = issued).
REQ-009 imem_rvalid  in  1  SHALL mark an in-order response, arriving at least 1 cycle after issue.
REQ-010 imem_rdata  in  32  SHALL be the response instruction word.
REQ-011 redirect  in  1  SHALL mark a taken branch/jump from the PC stage.
REQ-012 redirect_pc  in  32  SHALL be the new fetch target.
REQ-013 ins  out  32  SHALL be the head instruction to decode.
REQ-014 ins_pc  out  32  SHALL be the address of ins; PCp4 out 32 SHALL be ins_pc+4.
REQ-015 ins_valid  out  1  SHALL indicate the queue head is valid.
REQ-016 ins_ready  in  1  SHALL be the decode accept; pop = ins_valid&ins_ready.

Function
REQ-017 Issue SHALL occur when occupancy+outstanding < DEPTH, outstanding < MAX_OUT, and redirect is low; imem_req SHALL be combinational on these terms.
REQ-018 The fetch PC SHALL advance by 4 on each issue, wrapping modulo 2^32.
REQ-019 Each non-discarded response SHALL push {pc, rdata} into the queue; pc SHALL come from an in-order tag FIFO of issued addresses.
REQ-020 Latency SHALL be 1 cycle from the response edge to ins_valid (registered queue, no bypass).
REQ-021 Push and pop SHALL be permitted in the same cycle when the queue is full; occupancy is then unchanged.
REQ-022 ins/ins_pc SHALL hold stable while ins_valid=1 and ins_ready=0.
REQ-023 On redirect: the queue SHALL flush next edge, fetch PC SHALL load {redirect_pc[31:2],2'b00}, outstanding count SHALL transfer to a discard counter, and no issue SHALL occur that cycle.
REQ-024 Responses SHALL be dropped while the discard counter is nonzero, decrementing it by 1 each.
REQ-025 Redirect SHALL take priority over a simultaneous pop, push, or issue; the popped instruction counts as consumed.
REQ-026 Back-to-back redirects SHALL each take effect; the last target SHALL win, and discard SHALL accumulate (discard + outstanding).
REQ-027 ins_valid SHALL be 0 whenever occupancy is 0; ins SHALL then read 32'h00000013 (NOP).
REQ-028 An imem_rvalid with zero outstanding and zero discard SHALL be ignored (protocol error, no state change).

Reset
REQ-029 While INT=1: fetch PC=entryPoint; queue, outstanding, and discard=0; ins_valid=0; imem_req=0; ins=NOP; ins_pc=entryPoint; PCp4=entryPoint+4.
REQ-030 INT asserted mid-operation SHALL abort all in-flight state immediately; responses after deassertion with no outstanding request are ignored per REQ-028.
REQ-031 Fetching SHALL begin the first edge after INT deasserts.

Configuration
REQ-032 With PF_STATS_EN defined: 32-bit outputs stat_fetched (pushes) and stat_flushed (entries + discards dropped) SHALL count, saturate at 2^32-1, and clear on INT.
REQ-033 Without PF_STATS_EN, these ports and counters SHALL not exist.

Structure
REQ-034 Shared package y_pkg SHALL hold XLEN=32, NOP_INS=32'h00000013, and the queue-entry typedef {pc, ins}.
REQ-035 The queue SHALL be a sub-module y_pf_fifo (synchronous, flush input, count output), reused for the tag FIFO.

Verification
REQ-036 INT high with entryPoint=0x80, release, gnt=1, 1-cycle rvalid -> addresses 0x80, 0x84, 0x88...; first ins_valid with ins_pc=0x80 after 2 edges of the response path.
REQ-037 ins_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, imem_req=0, ins_pc=0x80 stable.
REQ-038 Redirect to 0x203 with 2 outstanding -> next imem_addr=0x200, two stale responses dropped, first delivered ins_pc=0x200.
REQ-039 Full queue with simultaneous pop and push -> occupancy stays 4 and order is preserved.
REQ-040 INT pulse mid-stream with outstanding=2 -> ins_valid=0 immediately; late rvalid ignored; refetch from entryPoint.
REQ-041 Fetch PC 0xFFFFFFFC -> next address 0x00000000 (wrap).
